// File: rtl/seq_stream_pkg.sv
// Shared constants, state encoding and helpers for the serial pattern front-end.
package seq_stream_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned DEF_PAT_W = 8;
  localparam int unsigned DEF_LEN_W = 4;
  localparam int unsigned DEF_CNT_W = 8;

  // One-hot controller states
  localparam int unsigned ST_W = 5;
  localparam logic [ST_W-1:0] ST_IDLE  = 5'b00001;
  localparam logic [ST_W-1:0] ST_ARM   = 5'b00010;
  localparam logic [ST_W-1:0] ST_WAIT  = 5'b00100;
  localparam logic [ST_W-1:0] ST_SHIFT = 5'b01000;
  localparam logic [ST_W-1:0] ST_DONE  = 5'b10000;

  typedef enum logic [ST_W-1:0] {
    S_IDLE  = ST_IDLE,
    S_ARM   = ST_ARM,
    S_WAIT  = ST_WAIT,
    S_SHIFT = ST_SHIFT,
    S_DONE  = ST_DONE
  } state_t;

  localparam logic [7:0]  RST_PAT = 8'h0D;
  localparam int unsigned RST_LEN = 4;
  localparam int unsigned RST_MAX = 0;

  // A zero length would match every bit; anything past the window is unreachable
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned pat_w);
    if (len == 0) return 1;
    if (len > pat_w) return pat_w;
    return len;
  endfunction

endpackage

// File: rtl/seq_stream_ctrl_if.sv
// Byte stream handshake into the serialiser.
interface seq_stream_ctrl_if;
  import seq_stream_pkg::*;

  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;

  modport master (output in_valid, in_data, in_last, input in_ready);
  modport slave  (input in_valid, in_data, in_last, output in_ready);
endinterface

// File: rtl/seq_stream_ctrl_pat_window.sv
// Shift window with saturating fill and length-masked compare of the incoming bit.
module pat_window #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pat,
  input  logic [LEN_W-1:0] len,
  output logic             match_c
);

  logic [PAT_W-1:0] window;
  logic [PAT_W-1:0] window_nx;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] fill;
  logic [LEN_W-1:0] fill_inc;

  assign window_nx = {window[PAT_W-2:0], bit_in};
  assign fill_inc  = (fill >= len) ? fill : LEN_W'(fill + 1'b1);
  assign mask      = ~({PAT_W{1'b1}} << len);
  assign match_c   = shift_en && (fill_inc >= len) && ((window_nx & mask) == (pat & mask));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      window <= '0;
      fill   <= '0;
    end else if (shift_en) begin
      window <= window_nx;
      fill   <= fill_inc;
    end
  end

endmodule

// File: rtl/seq_stream_ctrl.sv
// Byte-to-bit serialiser feeding the pattern detectors, with its own match counter and frame control.
module seq_stream_ctrl
  import seq_stream_pkg::*;
#(
  parameter int unsigned PAT_W = DEF_PAT_W,
  parameter int unsigned LEN_W = DEF_LEN_W,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pat,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [CNT_W-1:0]  cfg_max,
  input  logic              start,
  input  logic              abort,
  seq_stream_ctrl_if.slave  stream,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              hit,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic              busy,
  output logic              done
);

  state_t            state;
  logic [BYTE_W-1:0] shreg;
  logic [IDX_W-1:0]  idx;
  logic              last_q;
  logic [PAT_W-1:0]  pat_q;
  logic [LEN_W-1:0]  len_q;
  logic [CNT_W-1:0]  max_q;

  logic              idle_or_done_c;
  logic              shift_en_c;
  logic              match_c;
  logic [CNT_W-1:0]  cnt_inc_c;
  logic              limit_c;
  logic              in_ready_c;
  logic              take_c;

  // The bit on the line is always the MSB of the shifter, so it leaves straight from a flop
  assign bit_out = shreg[BYTE_W-1];

  assign idle_or_done_c = (state == S_IDLE) || (state == S_DONE);
  assign shift_en_c     = (state == S_SHIFT) && !abort;
  assign cnt_inc_c      = (&hit_cnt) ? hit_cnt : CNT_W'(hit_cnt + 1'b1);
  assign limit_c        = (max_q != '0) && match_c && (cnt_inc_c == max_q);

  // Ready must see this cycle's limit hit, so it cannot be registered
  assign in_ready_c = !abort &&
                      ((state == S_WAIT) ||
                       ((state == S_SHIFT) && (idx == '0) && !last_q && !limit_c));
  assign take_c          = in_ready_c && stream.in_valid;
  assign stream.in_ready = in_ready_c;

  pat_window #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_window (
    .clk      (clk),
    .rst      (rst),
    .clr      (state == S_ARM),
    .shift_en (shift_en_c),
    .bit_in   (bit_out),
    .pat      (pat_q),
    .len      (len_q),
    .match_c  (match_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      shreg     <= '0;
      idx       <= '0;
      last_q    <= 1'b0;
      bit_valid <= 1'b0;
      hit       <= 1'b0;
      hit_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pat_q     <= PAT_W'(RST_PAT);
      len_q     <= LEN_W'(RST_LEN);
      max_q     <= CNT_W'(RST_MAX);
    end else begin
      hit <= 1'b0;
      if (cfg_we && idle_or_done_c) begin
        pat_q <= cfg_pat;
        len_q <= LEN_W'(clamp_len(32'(cfg_len), PAT_W));
        max_q <= cfg_max;
      end
      if (abort) begin
        state     <= S_IDLE;
        bit_valid <= 1'b0;
        busy      <= 1'b0;
        done      <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              state <= S_ARM;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
          S_ARM: begin
            state   <= S_WAIT;
            hit_cnt <= '0;
          end
          S_WAIT: begin
            if (take_c) begin
              shreg     <= stream.in_data;
              idx       <= IDX_W'(BYTE_W - 1);
              last_q    <= stream.in_last;
              state     <= S_SHIFT;
              bit_valid <= 1'b1;
            end
          end
          S_SHIFT: begin
            hit <= match_c;
            if (match_c) hit_cnt <= cnt_inc_c;
            if (limit_c) begin
              state     <= S_DONE;
              bit_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else if (idx == '0) begin
              if (take_c) begin
                shreg  <= stream.in_data;
                idx    <= IDX_W'(BYTE_W - 1);
                last_q <= stream.in_last;
              end else if (last_q) begin
                state     <= S_DONE;
                bit_valid <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b1;
              end else begin
                state     <= S_WAIT;
                bit_valid <= 1'b0;
              end
            end else begin
              shreg <= {shreg[BYTE_W-2:0], 1'b0};
              idx   <= IDX_W'(idx - 1'b1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// Scoreboard bench for seq_stream_ctrl: stimulus queues expectations, a negedge monitor checks them.
module tb_seq_stream_ctrl;

  logic       clk;
  logic       rst;
  logic       cfg_we;
  logic [7:0] cfg_pat;
  logic [3:0] cfg_len;
  logic [7:0] cfg_max;
  logic       start;
  logic       abort;
  logic       bit_out;
  logic       bit_valid;
  logic       hit;
  logic [7:0] hit_cnt;
  logic       busy;
  logic       done;

  seq_stream_ctrl_if stream_if ();

  seq_stream_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_pat   (cfg_pat),
    .cfg_len   (cfg_len),
    .cfg_max   (cfg_max),
    .start     (start),
    .abort     (abort),
    .stream    (stream_if),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .hit       (hit),
    .hit_cnt   (hit_cnt),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         pos;
    logic [7:0] cnt;
  } hit_t;

  typedef struct {
    string      tag;
    bit         tmo;
    bit         chk_bo;
    logic       bo;
    logic       bv;
    logic       hp;
    logic       rdy;
    logic       by;
    logic       dn;
    logic [7:0] cnt;
  } lvl_t;

  logic  exp_bits[$];
  hit_t  exp_hits[$];
  int    exp_runs[$];
  lvl_t  exp_lvl[$];
  bit    fin_req = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- stimulus helpers ----------------
  task automatic push_bits(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) exp_bits.push_back(d[7-i]);
  endtask

  task automatic push_hit(input int pos, input logic [7:0] cnt);
    hit_t h;
    h.pos = pos;
    h.cnt = cnt;
    exp_hits.push_back(h);
  endtask

  task automatic push_lvl(input string tag, input bit chk_bo, input logic bv, input logic hp,
                          input logic rdy, input logic by, input logic dn, input logic [7:0] cnt);
    lvl_t l;
    l.tag = tag; l.tmo = 1'b0; l.chk_bo = chk_bo; l.bo = 1'b0;
    l.bv = bv; l.hp = hp; l.rdy = rdy; l.by = by; l.dn = dn; l.cnt = cnt;
    exp_lvl.push_back(l);
  endtask

  task automatic push_tmo(input string tag);
    lvl_t l;
    l = '{tag: tag, tmo: 1'b1, chk_bo: 1'b0, bo: 1'b0, bv: 1'b0, hp: 1'b0,
          rdy: 1'b0, by: 1'b0, dn: 1'b0, cnt: 8'h00};
    exp_lvl.push_back(l);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input logic [7:0] p, input logic [3:0] l, input logic [7:0] m);
    cfg_we = 1'b1; cfg_pat = p; cfg_len = l; cfg_max = m;
    next_cycle();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
  endtask

  // Returns in the cycle that presents the byte's first bit
  task automatic send_byte(input logic [7:0] d, input logic l);
    int n;
    stream_if.in_valid = 1'b1;
    stream_if.in_data  = d;
    stream_if.in_last  = l;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!stream_if.in_ready && n < 200);
    if (!stream_if.in_ready) push_tmo("send_byte");
    next_cycle();
    stream_if.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 200);
    if (!done) push_tmo(tag);
    next_cycle();
  endtask

  task automatic frame_da(input string tag);
    push_bits(8'hDA, 8);
    exp_runs.push_back(8);
    push_hit(4, 8'd1);
    push_hit(7, 8'd2);
    pulse_start();
    send_byte(8'hDA, 1'b1);
    wait_done(tag);
    push_lvl(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_pat = '0; cfg_len = '0; cfg_max = '0;
    start = 1'b0; abort = 1'b0;
    stream_if.in_valid = 1'b0; stream_if.in_data = '0; stream_if.in_last = 1'b0;
    repeat (3) next_cycle();
    rst = 1'b0;
    push_lvl("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    next_cycle();

    // Reset config: 1101 over 8'hDA
    frame_da("t1_da");

    // Back-to-back bytes, pattern spanning the byte boundary
    write_cfg(8'h06, 4'd4, 8'd0);
    push_bits(8'h01, 8);
    push_bits(8'hA0, 8);
    exp_runs.push_back(16);
    push_hit(10, 8'd1);
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'hA0, 1'b1);
    wait_done("t2_b2b");
    push_lvl("t2_b2b", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);

    // Hit limit of 1 on the first bit
    write_cfg(8'h01, 4'd1, 8'd1);
    push_bits(8'hFF, 1);
    exp_runs.push_back(1);
    push_hit(1, 8'd1);
    pulse_start();
    send_byte(8'hFF, 1'b0);
    next_cycle();
    push_lvl("t3_limit", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1);
    next_cycle();
    push_lvl("t3_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);

    // Abort on the third bit; a config write mid-frame must be ignored
    write_cfg(8'h01, 4'd1, 8'd0);
    push_bits(8'hF0, 3);
    exp_runs.push_back(3);
    push_hit(1, 8'd1);
    push_hit(2, 8'd2);
    pulse_start();
    send_byte(8'hF0, 1'b1);
    cfg_we = 1'b1; cfg_pat = 8'h00; cfg_len = 4'd4; cfg_max = 8'd0;
    next_cycle();
    cfg_we = 1'b0;
    next_cycle();
    abort = 1'b1;
    next_cycle();
    abort = 1'b0;
    push_lvl("t4_abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);

    // Length 0 acts as 1
    write_cfg(8'h01, 4'd0, 8'd0);
    push_bits(8'hA5, 8);
    exp_runs.push_back(8);
    push_hit(1, 8'd1);
    push_hit(3, 8'd2);
    push_hit(6, 8'd3);
    push_hit(8, 8'd4);
    pulse_start();
    send_byte(8'hA5, 1'b1);
    wait_done("t4_len0");
    push_lvl("t4_len0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4);

    // Length 12 acts as 8
    write_cfg(8'hA5, 4'd12, 8'd0);
    push_bits(8'hA5, 8);
    exp_runs.push_back(8);
    push_hit(8, 8'd1);
    pulse_start();
    send_byte(8'hA5, 1'b1);
    wait_done("t4_len12");
    push_lvl("t4_len12", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);

    // Reset in the middle of a byte, then the reset config must be back
    write_cfg(8'h03, 4'd2, 8'd5);
    push_bits(8'h00, 5);
    exp_runs.push_back(5);
    pulse_start();
    send_byte(8'h00, 1'b1);
    repeat (4) next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    push_lvl("t5_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    next_cycle();
    frame_da("t5_da");

    repeat (2) next_cycle();
    fin_req = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  int   frame_bits = 0;
  int   run = 0;
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    if (busy === 1'b1 && prev_busy !== 1'b1) frame_bits = 0;

    if (hit === 1'b1) begin
      if (exp_hits.size() == 0) begin
        check("unexpected_hit_pos", 32'(frame_bits), 32'hFFFF_FFFF);
      end else begin
        hit_t h;
        h = exp_hits.pop_front();
        check("hit_pos", 32'(frame_bits), 32'(h.pos));
        check("hit_cnt", 32'(hit_cnt), 32'(h.cnt));
      end
    end

    if (bit_valid === 1'b1) begin
      if (exp_bits.size() == 0) begin
        check("unexpected_bit", 32'(bit_out), 32'hFFFF_FFFF);
      end else begin
        logic b;
        b = exp_bits.pop_front();
        check("bit_out", 32'(bit_out), 32'(b));
      end
      frame_bits++;
      run++;
    end else if (run != 0) begin
      if (exp_runs.size() == 0) begin
        check("unexpected_run", 32'(run), 32'hFFFF_FFFF);
      end else begin
        int r;
        r = exp_runs.pop_front();
        check("bit_run_len", 32'(run), 32'(r));
      end
      run = 0;
    end

    if (exp_lvl.size() != 0) begin
      lvl_t l;
      l = exp_lvl.pop_front();
      if (l.tmo) begin
        n_vec++;
        n_err++;
        $display("FAIL timeout %s: wait bound expired", l.tag);
      end else begin
        check({"levels_", l.tag},
              32'({(l.chk_bo ? bit_out : 1'b0), bit_valid, hit, stream_if.in_ready, busy, done, hit_cnt}),
              32'({(l.chk_bo ? l.bo : 1'b0), l.bv, l.hp, l.rdy, l.by, l.dn, l.cnt}));
      end
    end

    prev_busy = busy;

    if (fin_req) begin
      check("pending_bits", 32'(exp_bits.size()), 32'd0);
      check("pending_hits", 32'(exp_hits.size()), 32'd0);
      check("pending_runs", 32'(exp_runs.size()), 32'd0);
      check("pending_levels", 32'(exp_lvl.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
    end
  end

endmodule

// File: doc/seq_stream_ctrl.md
Name: seq_stream_ctrl

Overview:
- Front-end controller for the serial pattern detectors.
- Accepts bytes over a valid/ready handshake and serialises them MSB-first onto a single-bit detector input. Drives that bit on the rising edge, giving the falling-edge detectors half a cycle of setup.
- Runs its own programmable pattern window, counts matches and terminates a frame on last-byte or hit-limit.
- Software programs pattern, length and limit, then arms with start.

Parameters:
- PAT_W, 8, maximum pattern length in bits.
- LEN_W, 4, width of the length field; must hold PAT_W.
- CNT_W, 8, width of the hit counter and hit limit.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- cfg_we  in  1  config write strobe; honoured only in IDLE or DONE.
- cfg_pat  in  PAT_W  pattern; LSB is the most recent bit.
- cfg_len  in  LEN_W  pattern length.
- cfg_max  in  CNT_W  hit limit; 0 = unlimited.
- start  in  1  arm and clear counters; ignored while busy.
- abort  in  1  return to IDLE from any state.
- in_valid  in  1  byte valid.
- in_data  in  8  byte, sent MSB first.
- in_last  in  1  final byte of the frame.
- in_ready  out  1  byte accepted when in_valid & in_ready.
- bit_out  out  1  serial bit to the detectors.
- bit_valid  out  1  bit_out is meaningful this cycle.
- hit  out  1  one-cycle match pulse.
- hit_cnt  out  CNT_W  matches this frame.
- busy  out  1  in ARM, WAIT or SHIFT.
- done  out  1  level, high in DONE.

Behaviour:
- Reset: all outputs 0, state IDLE, window cleared, config pat=8'h0D, len=4, max=0.
- Config clamping: len 0 stored as 1; len > PAT_W stored as PAT_W.
- States are one-hot: IDLE, ARM, WAIT, SHIFT, DONE.
- IDLE / DONE:
  - in_ready=0, bit_valid=0.
  - start -> ARM.
  - done stays high in DONE until start, abort or rst.
- ARM (one cycle): clear window, fill counter, hit_cnt and done -> WAIT.
- WAIT: in_ready=1. On handshake, load shift register, idx=7, latch in_last -> SHIFT.
- SHIFT, each cycle:
  - bit_out = shreg[idx], bit_valid=1.
  - window <= {window[PAT_W-2:0], bit_out}.
  - fill saturates at len.
  - idx decrements.
- Back-to-back bytes: in_ready=1 in SHIFT when idx==0, latched last==0 and the limit is not hit this cycle. A handshake there reloads with no bubble.
- Byte end (idx==0, no new byte): last -> DONE, else -> WAIT.
- Match rule: bit presented in cycle t completes a match if fill (including that bit) >= len and the low len bits of the window equal the low len bits of pat.
  - Result: hit=1 and hit_cnt+1, both visible in cycle t+1.
  - Overlapping matches count.
  - The window persists across bytes, so patterns spanning bytes are detected.
- Counter: hit_cnt saturates at all-ones.
- Limit: if cfg_max != 0 and the incremented count equals cfg_max, next state is DONE. Remaining bits are dropped and the pending byte is not accepted.
- Priority: rst > abort > limit > in_last end > normal.
- Abort: any non-IDLE state -> IDLE next cycle. bit_valid=0 and done=0 from then on; hit_cnt is retained; no hit pulse is issued for that cycle's bit.
- Same cycle as DONE entry: last-bit match and limit together both count; the hit pulse still fires.
- Ignored inputs: start outside IDLE/DONE; cfg_we outside IDLE/DONE.
- Reset mid-frame: immediate return to reset values; the partial byte is discarded.

Decomposition:
- seq_stream_pkg holds:
  - one-hot state localparams (5 bits);
  - reset config constants RST_PAT=8'h0D, RST_LEN=4, RST_MAX=0.
- Sub-module pat_window holds:
  - the PAT_W shift window;
  - the saturating fill counter;
  - the length-masked compare, producing a combinational match for the incoming bit.
- The top level keeps the FSM, handshake, serialiser and counters.

Test Plan:
1. Reset defaults, start, byte 8'hDA with last -> bit_out 1,1,0,1,1,0,1,0 over 8 consecutive cycles; hit after the 4th and 7th bits; hit_cnt=2; done=1.
2. cfg pat=4'b0110 len=4, bytes 8'h01 then 8'hA0 (last) with in_valid held -> 16 consecutive bit_valid cycles, no bubble; single hit after bit 10; hit_cnt=1.
3. cfg pat=1 len=1 max=1, byte 8'hFF -> hit after the first bit, DONE next cycle, bit_valid=0, in_ready=0, hit_cnt=1.
4. Abort after 3 bits of 8'hF0 -> IDLE next cycle, bit_valid=0, done=0, hit_cnt retained; cfg_we during SHIFT has no effect; cfg_len=0 behaves as 1, cfg_len=12 as 8.
5. rst asserted mid-SHIFT -> all outputs 0 next cycle; config reverts to 8'h0D/4/0; a fresh start with 8'hDA reproduces test 1.
